// File: rtl/ntt_bitrev_loader_if.sv
// Handshake bundle between the NTT input stager and its neighbours:
// word input on the in_* side and coefficient stream on the out_* side.
interface ntt_bitrev_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_coeff;
    logic [2:0]  out_idx;
    logic        out_last;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, out_coeff, out_idx, out_last
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, out_coeff, out_idx, out_last
    );
endinterface

// File: rtl/ntt_bitrev_loader.sv
// Ping-pong staging of 8x8-bit coefficient words, stored in bit-reversed lane
// positions and streamed one coefficient (mod Q) per beat to the butterfly stage.
module ntt_bitrev_loader #(
    parameter int unsigned Q      = 17,
    parameter bit          BITREV = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ntt_bitrev_loader_if.slave   bus
);
    localparam int unsigned LANES = 8;
    localparam int unsigned CW    = 8;
    localparam int unsigned IW    = 3;
    localparam int unsigned RW    = 9;

    logic [CW-1:0] bank_q [2][LANES];
    logic [CW-1:0] bank_d [2][LANES];
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          accept_c;
    logic          beat_c;
    logic [CW-1:0] cur_c;

    function automatic logic [IW-1:0] bitrev3(input logic [IW-1:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // Handshake outputs come straight from registered state only.
    assign bus.in_ready  = ~full_q[wr_bank_q];
    assign bus.out_valid = full_q[rd_bank_q];
    assign cur_c         = bank_q[rd_bank_q][cnt_q];
    assign bus.out_coeff = CW'({1'b0, cur_c} % RW'(Q));
    assign bus.out_idx   = cnt_q;
    assign bus.out_last  = full_q[rd_bank_q] && (cnt_q == IW'(LANES - 1));

    assign accept_c = bus.in_valid && !full_q[wr_bank_q];
    assign beat_c   = full_q[rd_bank_q] && bus.out_ready;

    // Write and drain always hit different banks: the write bank is empty when accepting.
    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        cnt_d     = cnt_q;
        if (accept_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                bank_d[wr_bank_q][BITREV ? bitrev3(IW'(i)) : IW'(i)] = bus.data_in[CW*i +: CW];
            end
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (beat_c) begin
            if (cnt_q == IW'(LANES - 1)) begin
                cnt_d             = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                cnt_d = cnt_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q    <= '{default: '0};
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            bank_q    <= bank_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ntt_bitrev_loader.sv
// Bench for ntt_bitrev_loader: two instances (bit-reversed and natural order) share
// one stimulus; a word-queue model predicts every output each cycle.
module tb_ntt_bitrev_loader;
    localparam int unsigned Q = 17;
    localparam int unsigned ORD [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    ntt_bitrev_loader_if b1 ();
    ntt_bitrev_loader_if b0 ();

    ntt_bitrev_loader #(.Q(Q), .BITREV(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    ntt_bitrev_loader #(.Q(Q), .BITREV(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    logic rdy_man = 1'b1;
    logic rdy_pat = 1'b1;
    bit   bp_en   = 1'b0;
    int   bp_i    = 0;
    logic [15:0] lfsr = 16'hACE1;
    logic [3:0]  pat4 = 4'b1001;

    assign b1.out_ready = bp_en ? rdy_pat : rdy_man;
    assign b0.out_ready = b1.out_ready;
    assign b0.in_valid  = b1.in_valid;
    assign b0.data_in   = b1.data_in;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    // out_ready pattern: 1,0,0,1 then pseudo-random
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            if (bp_i < 4) begin
                rdy_pat = pat4[3 - bp_i];
            end else begin
                lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                rdy_pat = lfsr[0];
            end
            bp_i++;
        end
    end

    // Model: FIFO of at most two accepted words plus the beat position in the head word.
    logic [63:0] mq [$];
    int          beat = 0;
    bit          m_fire_out, m_fire_in;

    function automatic int exp_coeff(input logic [63:0] w, input int b, input bit rev);
        int lane;
        lane = rev ? int'(ORD[b]) : b;
        return int'(w[8*lane +: 8]) % int'(Q);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            beat = 0;
        end else begin
            m_fire_out = (mq.size() > 0) && b1.out_ready;
            m_fire_in  = b1.in_valid && (mq.size() < 2);
            if (m_fire_out) begin
                if (beat == 7) begin
                    beat = 0;
                    void'(mq.pop_front());
                end else begin
                    beat++;
                end
            end
            if (m_fire_in) mq.push_back(b1.data_in);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] log1 [$];
    logic [7:0] log0 [$];
    bit         ev;

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        ev = mq.size() > 0;
        chk("in_ready1",  int'(b1.in_ready),  int'(mq.size() < 2));
        chk("in_ready0",  int'(b0.in_ready),  int'(mq.size() < 2));
        chk("out_valid1", int'(b1.out_valid), int'(ev));
        chk("out_valid0", int'(b0.out_valid), int'(ev));
        chk("out_last1",  int'(b1.out_last),  int'(ev && beat == 7));
        chk("out_last0",  int'(b0.out_last),  int'(ev && beat == 7));
        if (ev) begin
            chk("out_coeff1", int'(b1.out_coeff), exp_coeff(mq[0], beat, 1'b1));
            chk("out_coeff0", int'(b0.out_coeff), exp_coeff(mq[0], beat, 1'b0));
            chk("out_idx1",   int'(b1.out_idx),   beat);
            chk("out_idx0",   int'(b0.out_idx),   beat);
            if (b1.out_ready) begin
                log1.push_back(b1.out_coeff);
                log0.push_back(b0.out_coeff);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] w, output int acc_edge);
        bit r;
        bit done;
        done        = 1'b0;
        acc_edge    = -1;
        b1.data_in  = w;
        b1.in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            r = b1.in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                done     = 1'b1;
                acc_edge = cyc_n;
            end
        end
        b1.in_valid = 1'b0;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic chk_seq(input string name, input logic [7:0] q [$], input int e [8]);
        chk({name, "_len"}, q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < q.size()) chk(name, int'(q[k]), e[k]);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, int'(b1.out_valid), 0);
        chk({name, "_ready"}, int'(b1.in_ready),  1);
        chk({name, "_idx"},   int'(b1.out_idx),   0);
        chk({name, "_coeff"}, int'(b1.out_coeff), 0);
        chk({name, "_last"},  int'(b1.out_last),  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int e_ord [8];
        int e_nat [8];
        int e_red1 [8];
        int e_red0 [8];
        int ea, eb, ec, dummy;

        e_ord  = '{0, 4, 2, 6, 1, 5, 3, 7};
        e_nat  = '{0, 1, 2, 3, 4, 5, 6, 7};
        e_red1 = '{0, 16, 0, 0, 16, 0, 1, 0};
        e_red0 = '{0, 16, 0, 1, 16, 0, 0, 0};

        b1.in_valid = 1'b0;
        b1.data_in  = '0;
        #1;
        chk_reset_outputs("reset_low");
        cyc(2);
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("reset_after");

        // Lane order, bit-reversed and natural
        log1.delete(); log0.delete();
        send(64'h0706050403020100, dummy);
        cyc(10);
        chk_seq("order_bitrev", log1, e_ord);
        chk_seq("order_natural", log0, e_nat);

        // Reduction mod 17
        log1.delete(); log0.delete();
        send(64'hFFEE222112111000, dummy);
        cyc(10);
        chk_seq("reduce_bitrev", log1, e_red1);
        chk_seq("reduce_natural", log0, e_red0);

        // Backpressure with irregular out_ready
        log1.delete(); log0.delete();
        bp_en = 1'b1;
        send(64'h3F2E1D0C0B0A0908, dummy);
        send(64'hC8B7A69584736251, dummy);
        cyc(120);
        bp_en = 1'b0;
        cyc(2);
        chk("bp_count", log1.size(), 16);
        for (int k = 0; k < 16 && k < log1.size(); k++) begin
            chk("bp_seq", int'(log1[k]),
                exp_coeff(k < 8 ? 64'h3F2E1D0C0B0A0908 : 64'hC8B7A69584736251, k % 8, 1'b1));
        end

        // Ping-pong fill: A, B back to back, C stalled until after A's last beat
        log1.delete(); log0.delete();
        rdy_man = 1'b1;
        send(64'h0102030405060708, ea);
        send(64'h1112131415161718, eb);
        send(64'h2122232425262728, ec);
        chk("pp_b_edge", eb - ea, 1);
        chk("pp_c_edge", ec - ea, 9);
        cyc(15);
        @(negedge clk);
        chk("pp_beats", log1.size(), 24);
        chk("pp_drained", int'(b1.out_valid), 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a word at beat 3
        send(64'h0706050403020100, dummy);
        cyc(3);
        chk("mid_idx", int'(b1.out_idx), 3);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        cyc(2);
        rst_n = 1'b1;
        log1.delete(); log0.delete();
        send(64'h0000000000000005, dummy);
        #1;
        chk("restart_idx", int'(b1.out_idx), 0);
        cyc(10);
        chk("restart_count", log1.size(), 8);
        if (log1.size() > 0) chk("restart_first1", int'(log1[0]), 5);
        if (log0.size() > 0) chk("restart_first0", int'(log0[0]), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
